// File: rtl/lcd_image_pkg.sv
// Shared types and constants for the 8x8 LCD image controller.
// Command codes, FSM states and the operation-point limits live here.
package lcd_image_pkg;

    typedef enum logic [3:0] {
        CMD_WRITE   = 4'd0,
        CMD_UP      = 4'd1,
        CMD_DOWN    = 4'd2,
        CMD_LEFT    = 4'd3,
        CMD_RIGHT   = 4'd4,
        CMD_MAX     = 4'd5,
        CMD_MIN     = 4'd6,
        CMD_AVG     = 4'd7,
        CMD_ROT_CCW = 4'd8,
        CMD_ROT_CW  = 4'd9,
        CMD_MIRX    = 4'd10,
        CMD_MIRY    = 4'd11
    } cmd_e;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        IDLE  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam logic [2:0]  POS_MIN  = 3'd2;
    localparam logic [2:0]  POS_MAX  = 3'd6;
    localparam logic [2:0]  INIT_POS = 3'd4;
    localparam int unsigned WIN_N    = 16;

    // Linear buffer index of an image pixel: row*8 + col.
    function automatic logic [5:0] pix_idx(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/lcd_window_alu.sv
// Combinational maximum, minimum and truncated average of the 16 window pixels.
module lcd_window_alu #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned N     = 16
) (
    input  logic [PIX_W-1:0] pix_i [N],
    output logic [PIX_W-1:0] max_o,
    output logic [PIX_W-1:0] min_o,
    output logic [PIX_W-1:0] avg_o
);

    localparam int unsigned LOG_N = $clog2(N);
    localparam int unsigned SW    = PIX_W + LOG_N;

    logic [SW-1:0]    sum;
    logic [PIX_W-1:0] max_v;
    logic [PIX_W-1:0] min_v;

    always_comb begin
        max_v = pix_i[0];
        min_v = pix_i[0];
        sum   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (pix_i[i] > max_v) max_v = pix_i[i];
            if (pix_i[i] < min_v) min_v = pix_i[i];
            sum = sum + SW'(pix_i[i]);
        end
    end

    assign max_o = max_v;
    assign min_o = min_v;
    assign avg_o = PIX_W'(sum >> LOG_N);

endmodule

// File: rtl/lcd_image_ctrl.sv
// 8x8 image controller: ROM load, 4x4 window commands, RAM write-back.
// Define LCD_MIRROR_EN to enable Mirror X / Mirror Y (commands 10/11); otherwise they are NOPs.
module lcd_image_ctrl #(
    parameter int unsigned IMG_W    = 8,
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned INIT_POS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [3:0]                     cmd,
    input  logic                           cmd_valid,
    output logic                           IROM_rd,
    output logic [$clog2(IMG_W*IMG_W)-1:0] IROM_A,
    input  logic [PIX_W-1:0]               IROM_Q,
    output logic                           IRAM_valid,
    output logic [$clog2(IMG_W*IMG_W)-1:0] IRAM_A,
    output logic [PIX_W-1:0]               IRAM_D,
    output logic                           busy,
    output logic                           done
);

    import lcd_image_pkg::*;

    localparam int unsigned   NPIX      = IMG_W * IMG_W;
    localparam int unsigned   AW        = $clog2(NPIX);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    state_e           state_q, state_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [2:0]       pos_x_q, pos_x_d;
    logic [2:0]       pos_y_q, pos_y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rom_rd_q, rom_rd_d;
    logic [AW-1:0]    rom_a_q, rom_a_d;
    logic             ram_valid_q, ram_valid_d;
    logic [AW-1:0]    ram_a_q, ram_a_d;
    logic [PIX_W-1:0] ram_d_q, ram_d_d;

    logic [PIX_W-1:0] buf_q [NPIX];
    logic [PIX_W-1:0] buf_d [NPIX];

    logic [5:0]       win_idx [WIN_N];
    logic [PIX_W-1:0] win     [WIN_N];
    logic [PIX_W-1:0] win_new [WIN_N];
    logic             win_we;
    logic [PIX_W-1:0] win_max, win_min, win_avg;

    // Window covers rows y-2..y+1 and cols x-2..x+1, local index r*4+c.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                win_idx[r*4+c] = pix_idx(pos_y_q - 3'd2 + 3'(r), pos_x_q - 3'd2 + 3'(c));
                win[r*4+c]     = buf_q[win_idx[r*4+c]];
            end
        end
    end

    lcd_window_alu #(
        .PIX_W (PIX_W),
        .N     (WIN_N)
    ) u_alu (
        .pix_i (win),
        .max_o (win_max),
        .min_o (win_min),
        .avg_o (win_avg)
    );

    always_comb begin
        win_we = 1'b0;
        for (int i = 0; i < int'(WIN_N); i++) win_new[i] = win[i];
        case (cmd_q)
            CMD_MAX: begin
                win_we = 1'b1;
                for (int i = 0; i < int'(WIN_N); i++) win_new[i] = win_max;
            end
            CMD_MIN: begin
                win_we = 1'b1;
                for (int i = 0; i < int'(WIN_N); i++) win_new[i] = win_min;
            end
            CMD_AVG: begin
                win_we = 1'b1;
                for (int i = 0; i < int'(WIN_N); i++) win_new[i] = win_avg;
            end
            CMD_ROT_CCW: begin
                win_we = 1'b1;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) win_new[r*4+c] = win[c*4+(3-r)];
            end
            CMD_ROT_CW: begin
                win_we = 1'b1;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) win_new[r*4+c] = win[(3-c)*4+r];
            end
`ifdef LCD_MIRROR_EN
            CMD_MIRX: begin
                win_we = 1'b1;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) win_new[r*4+c] = win[(3-r)*4+c];
            end
            CMD_MIRY: begin
                win_we = 1'b1;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) win_new[r*4+c] = win[r*4+(3-c)];
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rom_rd_d    = rom_rd_q;
        rom_a_d     = rom_a_q;
        ram_valid_d = ram_valid_q;
        ram_a_d     = ram_a_q;
        ram_d_d     = ram_d_q;
        buf_d       = buf_q;

        unique case (state_q)
            LOAD: begin
                // rom_rd_q marks that an address was issued last cycle, so IROM_Q is valid now.
                if (rom_rd_q) begin
                    buf_d[rom_a_q] = IROM_Q;
                    if (rom_a_q == LAST_ADDR) begin
                        rom_rd_d = 1'b0;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        rom_a_d = rom_a_q + 1'b1;
                    end
                end else begin
                    rom_rd_d = 1'b1;
                    rom_a_d  = '0;
                end
            end
            IDLE: begin
                if (cmd_valid && !busy_q) begin
                    busy_d  = 1'b1;
                    cmd_d   = cmd;
                    state_d = (cmd == CMD_WRITE) ? WRITE : EXEC;
                end
            end
            EXEC: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                case (cmd_q)
                    CMD_UP:    if (pos_y_q > POS_MIN) pos_y_d = pos_y_q - 3'd1;
                    CMD_DOWN:  if (pos_y_q < POS_MAX) pos_y_d = pos_y_q + 3'd1;
                    CMD_LEFT:  if (pos_x_q > POS_MIN) pos_x_d = pos_x_q - 3'd1;
                    CMD_RIGHT: if (pos_x_q < POS_MAX) pos_x_d = pos_x_q + 3'd1;
                    default: ;
                endcase
                if (win_we) begin
                    for (int i = 0; i < int'(WIN_N); i++) buf_d[win_idx[i]] = win_new[i];
                end
            end
            WRITE: begin
                if (!ram_valid_q) begin
                    ram_valid_d = 1'b1;
                    ram_a_d     = '0;
                    ram_d_d     = buf_q[0];
                end else if (ram_a_q == LAST_ADDR) begin
                    ram_valid_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    ram_a_d = ram_a_q + 1'b1;
                    ram_d_d = buf_q[ram_a_q + 1'b1];
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            cmd_q       <= '0;
            pos_x_q     <= 3'(INIT_POS);
            pos_y_q     <= 3'(INIT_POS);
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            rom_rd_q    <= 1'b0;
            rom_a_q     <= '0;
            ram_valid_q <= 1'b0;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rom_rd_q    <= rom_rd_d;
            rom_a_q     <= rom_a_d;
            ram_valid_q <= ram_valid_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
        end
    end

    // Image contents are reloaded after every reset, so the buffer needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign IROM_rd    = rom_rd_q;
    assign IROM_A     = rom_a_q;
    assign IRAM_valid = ram_valid_q;
    assign IRAM_A     = ram_a_q;
    assign IRAM_D     = ram_d_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_lcd_image_ctrl.sv
// Directed self-checking bench for lcd_image_ctrl with a pixel[i]=i ROM and a falling-edge RAM.
module tb_lcd_image_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic       busy;
    logic       done;

    logic [7:0] ram [64];
    int         done_cnt;
    int         total;
    int         bad;

`ifdef LCD_MIRROR_EN
    localparam logic [7:0] MIR18 = 8'h2D;
    localparam logic [7:0] MIR45 = 8'h12;
`else
    localparam logic [7:0] MIR18 = 8'h12;
    localparam logic [7:0] MIR45 = 8'h2D;
`endif

    lcd_image_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .IROM_rd    (IROM_rd),
        .IROM_A     (IROM_A),
        .IROM_Q     (IROM_Q),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial IROM_Q = 8'h00;
    initial done_cnt = 0;

    // ROM holds pixel[i]=i; ROM and RAM both act on the falling edge.
    always @(negedge clk) begin
        if (IROM_rd) IROM_Q = {2'b00, IROM_A};
        if (IRAM_valid) ram[IRAM_A] = IRAM_D;
        if (done) done_cnt = done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready", {31'b0, busy}, 32'd0);
    endtask

    task automatic fresh();
        int n;
        @(negedge clk);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_idle(n);
        check("load_cycles", n, 32'd65);
    endtask

    task automatic issue(input logic [3:0] c);
        int n;
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        wait_idle(n);
    endtask

    task automatic do_write();
        int n;
        cmd       = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("done_width", {31'b0, done}, 32'd0);
    endtask

    task automatic check_image(input string tag, input int r0, input int c0, input bit win_en,
                               input logic [7:0] val);
        logic [7:0] e;
        for (int i = 0; i < 64; i++) begin
            e = 8'(i);
            if (win_en && (i / 8) >= r0 && (i / 8) < r0 + 4 && (i % 8) >= c0 && (i % 8) < c0 + 4)
                e = val;
            check($sformatf("%s[%0d]", tag, i), {24'b0, ram[i]}, {24'b0, e});
        end
    endtask

    initial begin
        int n;
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        cmd       = 4'd0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rom_rd", {31'b0, IROM_rd}, 32'd0);
        check("rst_rom_a", {26'b0, IROM_A}, 32'd0);
        check("rst_ram_valid", {31'b0, IRAM_valid}, 32'd0);
        check("rst_ram_a", {26'b0, IRAM_A}, 32'd0);
        check("rst_ram_d", {24'b0, IRAM_D}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("load_first_rd", {31'b0, IROM_rd}, 32'd1);
        check("load_first_a", {26'b0, IROM_A}, 32'd0);
        wait_idle(n);
        check("load_cycles", n, 32'd64);
        check("load_rd_off", {31'b0, IROM_rd}, 32'd0);

        // Plain load and write-back.
        do_write();
        check_image("load", 0, 0, 1'b0, 8'h00);
        check("done_count", done_cnt, 32'd1);

        // Max on the default window without reloading.
        issue(4'd5);
        do_write();
        check_image("max", 2, 2, 1'b1, 8'h2D);

        fresh();
        issue(4'd6);
        do_write();
        check_image("min", 2, 2, 1'b1, 8'h12);

        fresh();
        issue(4'd7);
        do_write();
        check_image("avg", 2, 2, 1'b1, 8'h1F);

        // Up-shift clamps at y=2.
        fresh();
        repeat (5) issue(4'd1);
        issue(4'd5);
        do_write();
        check_image("top_max", 0, 2, 1'b1, 8'h1D);

        // Right and down clamp at 6.
        fresh();
        repeat (5) issue(4'd4);
        repeat (5) issue(4'd2);
        issue(4'd5);
        do_write();
        check_image("br_max", 4, 4, 1'b1, 8'h3F);

        fresh();
        issue(4'd9);
        do_write();
        check("rot_cw_18", {24'b0, ram[18]}, 32'h2A);
        check("rot_cw_21", {24'b0, ram[21]}, 32'h12);
        check("rot_cw_45", {24'b0, ram[45]}, 32'h15);
        check("rot_cw_0", {24'b0, ram[0]}, 32'h00);
        repeat (3) issue(4'd9);
        do_write();
        check_image("rot_cw_x4", 0, 0, 1'b0, 8'h00);

        fresh();
        issue(4'd8);
        do_write();
        check("rot_ccw_18", {24'b0, ram[18]}, 32'h15);
        check("rot_ccw_45", {24'b0, ram[45]}, 32'h2A);

        fresh();
        issue(4'd10);
        issue(4'd11);
        do_write();
        check("mirror_18", {24'b0, ram[18]}, {24'b0, MIR18});
        check("mirror_45", {24'b0, ram[45]}, {24'b0, MIR45});

        // Continuous cmd_valid: NOPs alternate busy 1/0.
        fresh();
        cmd       = 4'd12;
        cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("hs_busy%0d", k), {31'b0, busy}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        // Shift Right held for two edges: the second lands while busy and must be ignored.
        cmd = 4'd4;
        @(negedge clk);
        check("hs_right_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hs_right_done", {31'b0, busy}, 32'd0);
        issue(4'd5);
        do_write();
        check_image("hs_max", 2, 3, 1'b1, 8'h2E);

        // Asynchronous reset in the middle of a write.
        fresh();
        cmd       = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("wr_mid_valid", {31'b0, IRAM_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd1);
        check("arst_ram_valid", {31'b0, IRAM_valid}, 32'd0);
        check("arst_ram_a", {26'b0, IRAM_A}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_idle(n);
        check("reload_cycles", n, 32'd65);
        do_write();
        check_image("reload", 0, 0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_image_ctrl.md
Name: lcd_image_ctrl

Overview:
- Image-processing controller for an 8x8, 8-bit-per-pixel image.
- After reset it loads the image from an external sync-read ROM into an internal 64-byte buffer.
- It then executes host commands on a 4x4 window around a movable operation point.
- On a Write command it streams the buffer to an external RAM and pulses done.

Parameters:
- IMG_W, 8, image width and height in pixels (fixed square).
- PIX_W, 8, pixel bit width.
- INIT_POS, 4, initial X and Y of the operation point.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- cmd  in  4  command code.
- cmd_valid  in  1  cmd qualifier.
- IROM_rd  out  1  ROM read enable.
- IROM_A  out  6  ROM address (row*8+col).
- IROM_Q  in  8  ROM data; ROM updates it on the falling edge after IROM_rd/IROM_A.
- IRAM_valid  out  1  RAM write enable; RAM writes on the falling edge.
- IRAM_A  out  6  RAM write address.
- IRAM_D  out  8  RAM write data.
- busy  out  1  high = commands not accepted.
- done  out  1  one-cycle pulse after Write completes.

Behaviour:
- Reset values: busy=1, done=0, IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, point=(4,4), state=LOAD.
- All outputs are registered.

LOAD:
- Drive IROM_rd=1 and IROM_A=0..63, one address per cycle.
- Data for the address driven at rising edge t is captured at rising edge t+1.
- After capturing pixel 63: IROM_rd=0, busy=0, go to IDLE.

IDLE:
- A command is accepted on a rising edge where cmd_valid=1 and busy=0.
- busy goes 1 on that same edge.
- cmd_valid while busy=1 is ignored.

Command set:
- 0 Write: go to WRITE.
- 1 Shift Up: y=max(y-1,2).
- 2 Shift Down: y=min(y+1,6).
- 3 Shift Left: x=max(x-1,2).
- 4 Shift Right: x=min(x+1,6).
- Window: rows y-2..y+1, cols x-2..x+1. Local index (r,c), 0..3.
- 5 Max: all 16 window pixels = maximum.
- 6 Min: all 16 window pixels = minimum.
- 7 Average: all 16 window pixels = floor(sum/16); 12-bit sum, take bits [11:4].
- 8 Rotate CCW: new[r][c]=old[c][3-r].
- 9 Rotate CW: new[r][c]=old[3-c][r].
- 10 Mirror X (vertical flip): new[r][c]=old[3-r][c].
- 11 Mirror Y (horizontal flip): new[r][c]=old[r][3-c].
- 12-15: NOP.

Timing:
- Commands 1-15 complete in one cycle: result is written at the rising edge after acceptance, and busy returns 0 on that edge.
- Shifts at a boundary leave the point unchanged; this is not an error.

WRITE:
- Drive IRAM_valid=1 with IRAM_A=0..63 and IRAM_D=buffer[A], one per cycle.
- After address 63: IRAM_valid=0 and done=1 for exactly one cycle.
- The done rising edge follows the last RAM falling-edge write; busy=0 on the same edge.
- The buffer and point are preserved, so further commands are accepted.

Reset mid-operation:
- Aborts everything and returns to LOAD with reset values.
- The buffer contents are don't-care until reloaded.

Optional Feature:
- Macro LCD_MIRROR_EN.
- Defined: commands 10/11 perform Mirror X / Mirror Y as above.
- Undefined: 10/11 are one-cycle NOPs (busy pulses, image unchanged) and the mirror muxes are removed.

Decomposition:
- Package lcd_image_pkg:
  - command enum (CMD_WRITE..CMD_MIRY)
  - FSM state enum (LOAD, IDLE, EXEC, WRITE)
  - constants POS_MIN=2, POS_MAX=6, INIT_POS=4
- One sub-module, lcd_window_alu: combinational max/min/average of 16 pixels.
- Rotation, mirroring and the FSM stay in the top.

Test Plan:
- Load test: ROM pixel[i]=i, then Write -> RAM[i]==i for all 64; done pulses exactly once, one cycle wide.
- Max/Min/Avg: pixel[i]=i at point (4,4).
  - Max then Write -> rows 2-5, cols 2-5 all 0x2D.
  - Fresh run, Min -> 0x12.
  - Fresh run, Average -> 0x1F (31.5 truncated).
  - Pixels outside the window unchanged.
- Boundary: pixel[i]=i, five Shift Up, then Max, then Write -> rows 0-3, cols 2-5 = 0x1D. Repeat with Shift Right x5 and Shift Down x5 -> window rows 4-7, cols 4-7 = 0x3F.
- Rotate CW at (4,4) with pixel[i]=i, then Write:
  - RAM[18]=old[5*8+2]=0x2A
  - RAM[21]=0x12
  - Rotate CW 4x -> image identical to the original.
- Mirror X then Mirror Y at (4,4): RAM[18]=0x2D, RAM[45]=0x12 (with LCD_MIRROR_EN). Without the macro, the image is unchanged.
- Handshake: hold cmd_valid=1 continuously:
  - each non-write command keeps busy high exactly one cycle
  - commands issued while busy are ignored
  - async reset assertion during WRITE forces busy=1 and IRAM_valid=0 immediately
